// File: rtl/ysyx_22041071_mdu_ctrl.sv
// Sequencer around the shared iterative mul/div core: conditions operands, launches
// or bypasses the core, applies sign fix-up and holds the result under valid/ready.
module ysyx_22041071_mdu_ctrl #(
    parameter int XLEN = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    output logic              ready_in,
    input  logic [4:0]        ALU_ctrl,
    input  logic [XLEN-1:0]   src1,
    input  logic [XLEN-1:0]   src2,
    input  logic              flush,
    output logic              core_start,
    output logic              core_abort,
    output logic              core_is_div,
    output logic [XLEN-1:0]   core_a,
    output logic [XLEN-1:0]   core_b,
    input  logic              core_done,
    input  logic [2*XLEN-1:0] core_prod,
    input  logic [XLEN-1:0]   core_quot,
    input  logic [XLEN-1:0]   core_rem,
    output logic              valid_out,
    input  logic              ready_out,
    output logic [XLEN-1:0]   result,
    output logic              stall
);

    localparam logic [4:0] OP_MUL   = 5'd19;
    localparam logic [4:0] OP_MULH  = 5'd20;
    localparam logic [4:0] OP_MULHU = 5'd21;
    localparam logic [4:0] OP_MULW  = 5'd22;
    localparam logic [4:0] OP_DIV   = 5'd23;
    localparam logic [4:0] OP_DIVU  = 5'd24;
    localparam logic [4:0] OP_DIVW  = 5'd25;
    localparam logic [4:0] OP_DIVUW = 5'd26;
    localparam logic [4:0] OP_REM   = 5'd27;
    localparam logic [4:0] OP_REMU  = 5'd28;
    localparam logic [4:0] OP_REMUW = 5'd29;
    localparam logic [4:0] OP_REMW  = 5'd30;

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t     state_reg;
    logic [4:0] op_reg;
    logic       sa_reg;
    logic       sb_reg;

    function automatic logic [XLEN-1:0] w_sext(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    // ---------------- operand conditioning (combinational, latched at accept)
    logic            is_mdu, op_w, op_signed, op_div, op_rem, accept;
    logic [XLEN-1:0] ext1, ext2, mag_a, mag_b, min_val, special_val;
    logic            sa_in, sb_in, div_zero, div_ovf, special;

    always_comb begin
        is_mdu    = (ALU_ctrl >= OP_MUL) && (ALU_ctrl <= OP_REMW);
        op_w      = ALU_ctrl inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_REMUW, OP_REMW};
        op_signed = ALU_ctrl inside {OP_MUL, OP_MULH, OP_MULW, OP_DIV, OP_DIVW, OP_REM, OP_REMW};
        op_div    = (ALU_ctrl >= OP_DIV) && (ALU_ctrl <= OP_REMW);
        op_rem    = (ALU_ctrl >= OP_REM) && (ALU_ctrl <= OP_REMW);

        ext1 = op_w ? {{(XLEN-32){op_signed & src1[31]}}, src1[31:0]} : src1;
        ext2 = op_w ? {{(XLEN-32){op_signed & src2[31]}}, src2[31:0]} : src2;

        sa_in = op_signed & ext1[XLEN-1];
        sb_in = op_signed & ext2[XLEN-1];
        mag_a = sa_in ? -ext1 : ext1;
        mag_b = sb_in ? -ext2 : ext2;

        // Most-negative value at the op width, seen after sign extension
        min_val  = op_w ? {{(XLEN-32){1'b1}}, 32'h8000_0000} : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = op_div & (ext2 == '0);
        div_ovf  = op_div & op_signed & (ext1 == min_val) & (ext2 == '1);
        special  = div_zero | div_ovf;

        if (div_zero)
            special_val = op_rem ? ext1 : '1;
        else
            special_val = op_rem ? '0 : ext1;
        if (op_w)
            special_val = w_sext(special_val[31:0]);

        accept = valid_in & ready_in & is_mdu;
    end

    assign ready_in = (state_reg == IDLE);
    assign stall    = (state_reg != IDLE) | (valid_in & is_mdu);

    // ---------------- result fix-up from the latched op and core outputs
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, div_val, fix_res;
    logic              reg_w, reg_rem;

    always_comb begin
        reg_w    = op_reg inside {OP_DIVW, OP_DIVUW, OP_REMUW, OP_REMW};
        reg_rem  = (op_reg >= OP_REM) && (op_reg <= OP_REMW);
        prod_fix = (sa_reg ^ sb_reg) ? -core_prod : core_prod;
        quot_fix = (sa_reg ^ sb_reg) ? -core_quot : core_quot;
        rem_fix  = sa_reg ? -core_rem : core_rem;
        div_val  = reg_rem ? rem_fix : quot_fix;
        case (op_reg)
            OP_MUL:           fix_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
            OP_MULW:          fix_res = w_sext(prod_fix[31:0]);
            default:          fix_res = reg_w ? w_sext(div_val[31:0]) : div_val;
        endcase
    end

    // ---------------- sequencer
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= IDLE;
            op_reg      <= '0;
            sa_reg      <= 1'b0;
            sb_reg      <= 1'b0;
            core_start  <= 1'b0;
            core_abort  <= 1'b0;
            core_is_div <= 1'b0;
            core_a      <= '0;
            core_b      <= '0;
            result      <= '0;
            valid_out   <= 1'b0;
        end else begin
            core_start <= 1'b0;
            core_abort <= 1'b0;
            if (flush) begin
                // Flush wins over accept, core_done and ready_out
                state_reg  <= IDLE;
                valid_out  <= 1'b0;
                core_abort <= (state_reg == START) || (state_reg == WAIT);
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (accept) begin
                            op_reg      <= ALU_ctrl;
                            sa_reg      <= sa_in;
                            sb_reg      <= sb_in;
                            core_a      <= mag_a;
                            core_b      <= mag_b;
                            core_is_div <= op_div;
                            if (special) begin
                                result    <= special_val;
                                valid_out <= 1'b1;
                                state_reg <= DONE;
                            end else begin
                                core_start <= 1'b1;
                                state_reg  <= START;
                            end
                        end
                    end
                    START: state_reg <= WAIT;
                    WAIT: begin
                        if (core_done) begin
                            result    <= fix_res;
                            valid_out <= 1'b1;
                            state_reg <= DONE;
                        end
                    end
                    DONE: begin
                        if (ready_out) begin
                            valid_out <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22041071_mdu_ctrl.sv
// Directed bench for ysyx_22041071_mdu_ctrl; the core is emulated by driving
// core_done/core_prod/core_quot/core_rem with hand-computed values.
module tb_ysyx_22041071_mdu_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         valid_in;
    logic         ready_in;
    logic [4:0]   ALU_ctrl;
    logic [63:0]  src1, src2;
    logic         flush;
    logic         core_start, core_abort, core_is_div;
    logic [63:0]  core_a, core_b;
    logic         core_done;
    logic [127:0] core_prod;
    logic [63:0]  core_quot, core_rem;
    logic         valid_out;
    logic         ready_out;
    logic [63:0]  result;
    logic         stall;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ysyx_22041071_mdu_ctrl #(.XLEN(64)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
        .ALU_ctrl(ALU_ctrl), .src1(src1), .src2(src2), .flush(flush),
        .core_start(core_start), .core_abort(core_abort), .core_is_div(core_is_div),
        .core_a(core_a), .core_b(core_b), .core_done(core_done), .core_prod(core_prod),
        .core_quot(core_quot), .core_rem(core_rem), .valid_out(valid_out),
        .ready_out(ready_out), .result(result), .stall(stall)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an op for one cycle; returns 1ns after the accepting edge
    task automatic do_accept(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
        valid_in = 1'b1; ALU_ctrl = op; src1 = a; src2 = b;
        #1;
        chk("ready_in_at_accept", ready_in, 1);
        chk("stall_at_accept", stall, 1);
        tick();
        valid_in = 1'b0;
    endtask

    task automatic run_norm(input string tag, input logic [4:0] op, input logic [63:0] a,
                            input logic [63:0] b, input logic [63:0] ea, input logic [63:0] eb,
                            input logic ediv, input logic [127:0] prod, input logic [63:0] q,
                            input logic [63:0] r, input logic [63:0] eres);
        do_accept(op, a, b);
        chk({tag, "_core_start"}, core_start, 1);
        chk({tag, "_core_a"}, core_a, ea);
        chk({tag, "_core_b"}, core_b, eb);
        chk({tag, "_core_is_div"}, core_is_div, ediv);
        tick();
        chk({tag, "_start_pulse_end"}, core_start, 0);
        core_done = 1'b1; core_prod = prod; core_quot = q; core_rem = r;
        tick();
        core_done = 1'b0;
        chk({tag, "_valid_out"}, valid_out, 1);
        chk({tag, "_result"}, result, eres);
        $display("[TB] %s op=%0d src1=%h src2=%h result=%h", tag, op, a, b, result);
    endtask

    task automatic run_special(input string tag, input logic [4:0] op, input logic [63:0] a,
                               input logic [63:0] b, input logic [63:0] eres);
        do_accept(op, a, b);
        chk({tag, "_no_core_start"}, core_start, 0);
        chk({tag, "_valid_out"}, valid_out, 1);
        chk({tag, "_result"}, result, eres);
        $display("[TB] %s op=%0d src1=%h src2=%h result=%h", tag, op, a, b, result);
    endtask

    task automatic finish_done(input string tag);
        tick();
        chk({tag, "_released"}, valid_out, 0);
        chk({tag, "_ready_in"}, ready_in, 1);
    endtask

    initial begin
        reset = 1'b0; valid_in = 1'b0; ALU_ctrl = '0; src1 = '0; src2 = '0;
        flush = 1'b0; core_done = 1'b0; core_prod = '0; core_quot = '0; core_rem = '0;
        ready_out = 1'b1;
        tick(); tick();
        chk("rst_valid_out", valid_out, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_core_abort", core_abort, 0);
        chk("rst_core_is_div", core_is_div, 0);
        chk("rst_core_a", core_a, 0);
        chk("rst_core_b", core_b, 0);
        chk("rst_result", result, 0);
        chk("rst_ready_in", ready_in, 1);
        chk("rst_stall", stall, 0);
        reset = 1'b1;
        tick();

        // Signed divide / remainder with negative dividend
        run_norm("div_neg", 5'd23, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'd7, 64'd2, 1'b1,
                 '0, 64'd3, 64'd1, 64'hFFFF_FFFF_FFFF_FFFD);
        finish_done("div_neg");
        run_norm("rem_neg", 5'd27, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'd7, 64'd2, 1'b1,
                 '0, 64'd3, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        finish_done("rem_neg");

        // Divide by zero and signed overflow bypass the core
        run_special("divu_zero", 5'd24, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        finish_done("divu_zero");
        run_special("remu_zero", 5'd28, 64'd5, 64'd0, 64'd5);
        finish_done("remu_zero");
        run_special("div_ovf", 5'd23, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'h8000_0000_0000_0000);
        finish_done("div_ovf");
        run_special("remw_ovf", 5'd30, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
        finish_done("remw_ovf");
        run_special("divw_ovf", 5'd25, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'hFFFF_FFFF_8000_0000);
        finish_done("divw_ovf");
        run_special("remuw_zero", 5'd29, 64'h0000_0001_8000_0001, 64'h0000_0001_0000_0000,
                    64'hFFFF_FFFF_8000_0001);
        finish_done("remuw_zero");

        // Multiplies
        run_norm("mulw", 5'd22, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'h7FFF_FFFF, 64'd2, 1'b0,
                 128'h0000_0000_FFFF_FFFE, '0, '0, 64'hFFFF_FFFF_FFFF_FFFE);
        finish_done("mulw");
        run_norm("mulh", 5'd20, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1,
                 1'b0, 128'd1, '0, '0, 64'd0);
        finish_done("mulh");
        run_norm("mul_neg", 5'd19, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'd3, 64'd5, 1'b0,
                 128'd15, '0, '0, 64'hFFFF_FFFF_FFFF_FFF1);
        finish_done("mul_neg");

        // Non-MDU code is ignored
        valid_in = 1'b1; ALU_ctrl = 5'd5; src1 = 64'd1; src2 = 64'd1;
        #1;
        chk("nonmdu_stall", stall, 0);
        tick();
        valid_in = 1'b0;
        chk("nonmdu_ready_in", ready_in, 1);
        chk("nonmdu_no_start", core_start, 0);
        $display("[TB] nonmdu op=5 ignored ready_in=%0b", ready_in);

        // Backpressure in DONE
        ready_out = 1'b0;
        run_norm("mulhu_bp", 5'd21, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'd2, 1'b0, {64'd1, 64'hFFFF_FFFF_FFFF_FFFE}, '0, '0, 64'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid_out", valid_out, 1);
            chk("bp_result", result, 64'd1);
            chk("bp_stall", stall, 1);
            chk("bp_ready_in", ready_in, 0);
        end
        ready_out = 1'b1;
        finish_done("bp");
        $display("[TB] backpressure held 5 cycles result=%h", result);

        // Flush in WAIT together with core_done
        do_accept(5'd23, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
        tick();
        flush = 1'b1; core_done = 1'b1; core_quot = 64'd3; core_rem = 64'd1;
        tick();
        flush = 1'b0; core_done = 1'b0;
        chk("flush_core_abort", core_abort, 1);
        chk("flush_valid_out", valid_out, 0);
        chk("flush_ready_in", ready_in, 1);
        tick();
        chk("flush_abort_pulse_end", core_abort, 0);
        chk("flush_valid_out_after", valid_out, 0);
        $display("[TB] flush in WAIT with core_done: abort pulsed, valid_out=%0b", valid_out);

        // Flush with valid_in in IDLE: op not accepted
        valid_in = 1'b1; ALU_ctrl = 5'd23; src1 = 64'd9; src2 = 64'd3; flush = 1'b1;
        tick();
        valid_in = 1'b0; flush = 1'b0;
        chk("flush_idle_no_start", core_start, 0);
        chk("flush_idle_ready_in", ready_in, 1);
        chk("flush_idle_no_abort", core_abort, 0);
        $display("[TB] flush with valid_in in IDLE: not accepted");

        // Reset in the middle of WAIT
        do_accept(5'd19, 64'd6, 64'd7);
        tick();
        reset = 1'b0;
        tick();
        chk("midrst_core_start", core_start, 0);
        chk("midrst_core_abort", core_abort, 0);
        chk("midrst_core_is_div", core_is_div, 0);
        chk("midrst_core_a", core_a, 0);
        chk("midrst_core_b", core_b, 0);
        chk("midrst_result", result, 0);
        chk("midrst_valid_out", valid_out, 0);
        chk("midrst_ready_in", ready_in, 1);
        reset = 1'b1;
        $display("[TB] reset mid-WAIT: outputs cleared");
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ysyx_22041071_mdu_ctrl.md
Name: ysyx_22041071_mdu_ctrl

Overview:
- Sequencer for the shared iterative multiply/divide core in the EX stage; handles ALU_ctrl codes 19–30 produced by decode.
- Conditions operands (W-truncation, sign/zero-extension, absolute values) and launches the core, or bypasses it for RISC-V div-by-zero/overflow cases.
- Applies sign fix-up and result selection, then holds the result under a valid/ready handshake to the next stage.
- Stalls the upstream pipeline while busy; supports flush.

Parameters:
- XLEN, 64, operand/result width; the core product is 2*XLEN.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-low (reset==0 clears all state)
- valid_in  in  1  EX has an op
- ready_in  out  1  block can accept
- ALU_ctrl  in  5  op code; 19 mul, 20 mulh, 21 mulhu, 22 mulw, 23 div, 24 divu, 25 divw, 26 divuw, 27 rem, 28 remu, 29 remuw, 30 remw
- src1, src2  in  XLEN  operands (dividend/divisor)
- flush  in  1  abort current op
- core_start  out  1  one-cycle launch pulse
- core_abort  out  1  one-cycle pulse, flush while core busy
- core_is_div  out  1  0 multiply, 1 divide
- core_a, core_b  out  XLEN  unsigned magnitudes to core
- core_done  in  1  core result valid, one cycle
- core_prod  in  2*XLEN  unsigned product
- core_quot, core_rem  in  XLEN  unsigned quotient/remainder
- valid_out  out  1  result valid
- ready_out  in  1  downstream accepts
- result  out  XLEN  final result
- stall  out  1  freeze earlier stages

Behaviour:
- Reset (reset==0 at posedge): state IDLE; valid_out, core_start, core_abort, core_is_div = 0; core_a, core_b, result = 0.
- is_mdu = ALU_ctrl in 19..30. ready_in = (state==IDLE).
- Accept on valid_in & ready_in & is_mdu. valid_in with non-MDU code is ignored: no state change, no stall.
- stall = (state!=IDLE) | (valid_in & is_mdu).
- Operand prep (latched at accept):
  - W ops (22,25,26,29,30) use src[31:0]; signed ops sign-extend to 64 bits, unsigned ops zero-extend.
  - Signed ops are 20, 22, 23, 25, 27, 30. mul (19) is treated as signed; the low half is unaffected.
  - For signed ops: sa/sb = operand sign bits; core_a/core_b = two's-complement magnitudes.
  - Unsigned ops pass the extended values through.
- Special cases (div/rem ops only), checked at accept; core is not started:
  - divisor==0: quotient = all ones; remainder = extended dividend.
  - Signed overflow (dividend = most-negative value at the op width, divisor = -1): quotient = dividend; remainder = 0.
- FSM:
  - IDLE → DONE on accept of a special case; result is registered with valid_out=1 the next cycle.
  - IDLE → START on any other accept.
  - START: core_start=1 for exactly this cycle → WAIT.
  - WAIT: on core_done, compute fix-up, register result → DONE. core_done is ignored in all other states.
  - DONE: valid_out=1, result held stable; ready_out=1 → IDLE at the next edge. A new op is accepted no earlier than the following cycle.
- Fix-up:
  - Product: negate the 128-bit product if sa^sb.
  - 19 → lo 64; 20/21 → hi 64; 22 → sext(lo[31:0]).
  - Quotient is negated if sa^sb; remainder is negated if sa.
  - W div/rem results = sext(bit 31 of the 32-bit result).
- Minimum latency, accept → valid_out:
  - special case: 1 cycle
  - normal op: 2 cycles + core latency
- flush (any state, highest priority):
  - next state IDLE; valid_out=0.
  - core_abort=1 for one cycle if in START or WAIT.
  - A simultaneous core_done or ready_out is discarded.
  - flush together with valid_in in IDLE: the op is not accepted.
- reset==0 mid-operation: immediate return to IDLE; no core_abort pulse (the core is reset separately).

Test Plan:
- div (23), src1=-7, src2=2; core returns quot=3, rem=1 → result 0xFFFF_FFFF_FFFF_FFFD. rem (27), same operands → 0xFFFF_FFFF_FFFF_FFFF.
- divu (24), src1=5, src2=0 → no core_start, result 0xFFFF_FFFF_FFFF_FFFF one cycle after accept. remu (28), same operands → 5.
- div (23), src1=0x8000_0000_0000_0000, src2=-1 → result 0x8000_0000_0000_0000, no core_start. remw (30), src1=0x8000_0000, src2=-1 → 0.
- mulw (22), src1=0x7FFF_FFFF, src2=2 → core_a=0x7FFF_FFFF, core_b=2 → result 0xFFFF_FFFF_FFFF_FFFE. mulh (20), -1 × -1 → core_a=core_b=1 → result 0.
- Backpressure: ready_out=0 for 5 cycles in DONE → result and valid_out held stable, stall=1, ready_in=0; ready_out=1 → IDLE next cycle.
- flush asserted in WAIT in the same cycle as core_done → core_abort pulse, valid_out stays 0, state IDLE. reset=0 mid-WAIT → all outputs 0 the next cycle.
